// File: rtl/led_pwm_update_ctrl.sv
// led_pwm_update_ctrl: shadows decoded RGB frames and commits them to the PWM duties only on period_end
// Ports: clk/rst (async, active-high); store+frame_data = frame in ({cmd,r,g,b}); period_end = PWM wrap;
// test_mode = colour test pattern request; data_* = committed duties; update = duties just changed;
// pending = shadow holds uncommitted frame; reject = bad cmd dropped; overrun_cnt = saturating overwrite count
module led_pwm_update_ctrl #(
  parameter int TEST_DWELL = 64,
  parameter int OVR_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             store,
  input  logic [31:0]      frame_data,
  input  logic             period_end,
  input  logic             test_mode,
  output logic [9:0]       data_red,
  output logic [9:0]       data_green,
  output logic [9:0]       data_blue,
  output logic             update,
  output logic             pending,
  output logic             reject,
  output logic [OVR_W-1:0] overrun_cnt
);
  typedef enum logic [1:0] {IDLE, PENDING, TEST} state_t;
  state_t state;
  logic [29:0] shadow, saved, frame, color, duty;
  logic [7:0] dwell;
  logic [2:0] step;
  logic valid, bad;
  logic [OVR_W-1:0] ovr_next;
  assign valid = store && (frame_data[31:30] == 2'b00 || frame_data[31:30] == 2'b11);
  assign bad = store && (frame_data[31] ^ frame_data[30]);
  assign frame = frame_data[31:30] == 2'b11 ? '0 : frame_data[29:0];
  assign duty = {data_red, data_green, data_blue};
  assign ovr_next = &overrun_cnt ? overrun_cnt : overrun_cnt + 1'b1;
  always_comb color = step == 3'd0 ? {10'h3ff, 20'h0} :
                      step == 3'd1 ? {10'h0, 10'h3ff, 10'h0} :
                      step == 3'd2 ? {20'h0, 10'h3ff} :
                      step == 3'd3 ? {30{1'b1}} : 30'h0;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      {data_red, data_green, data_blue} <= '0;
      shadow <= '0;
      saved <= '0;
      update <= 1'b0;
      pending <= 1'b0;
      reject <= 1'b0;
      overrun_cnt <= '0;
      dwell <= '0;
      step <= '0;
    end else begin
      update <= 1'b0;
      reject <= bad;
      case (state)
        IDLE: begin
          if (test_mode) begin
            state <= TEST;
            dwell <= '0;
            step <= '0;
          end else if (valid) begin
            shadow <= frame;
            pending <= 1'b1;
            state <= PENDING;
          end
        end
        PENDING: begin
          if (test_mode) begin
            state <= TEST;
            dwell <= '0;
            step <= '0;
            if (valid) begin
              shadow <= frame;
              overrun_cnt <= ovr_next;
            end
          end else if (period_end) begin
            {data_red, data_green, data_blue} <= shadow;
            saved <= shadow;
            update <= 1'b1;
            // a store coinciding with the commit refills the shadow rather than overwriting it
            if (valid) shadow <= frame;
            else begin
              pending <= 1'b0;
              state <= IDLE;
            end
          end else if (valid) begin
            shadow <= frame;
            overrun_cnt <= ovr_next;
          end
        end
        TEST: begin
          if (period_end && !test_mode) begin
            // leaving test: restore pending frame if any, else the last normally committed duties
            {data_red, data_green, data_blue} <= pending ? shadow : saved;
            if (pending) saved <= shadow;
            update <= 1'b1;
            pending <= valid;
            state <= valid ? PENDING : IDLE;
            if (valid) shadow <= frame;
          end else begin
            if (period_end) begin
              {data_red, data_green, data_blue} <= color;
              update <= color != duty;
              dwell <= dwell == 8'(TEST_DWELL - 1) ? 8'd0 : dwell + 8'd1;
              if (dwell == 8'(TEST_DWELL - 1)) step <= step == 3'd4 ? 3'd0 : step + 3'd1;
            end
            if (valid) begin
              shadow <= frame;
              pending <= 1'b1;
              if (pending) overrun_cnt <= ovr_next;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_led_pwm_update_ctrl.sv
// tb_led_pwm_update_ctrl: directed plus random checks of led_pwm_update_ctrl against a frame-level model
`timescale 1ns/1ps
module tb_led_pwm_update_ctrl;
  localparam int TD = 2;
  logic clk = 1'b0;
  logic rst, store, period_end, test_mode;
  logic [31:0] frame_data;
  logic [9:0] data_red, data_green, data_blue;
  logic update, pending, reject;
  logic [7:0] overrun_cnt;
  int checks = 0;
  int failures = 0;
  bit m_test, m_pend, m_upd, m_rej;
  logic [29:0] m_sh, m_sv, m_du;
  int m_ovr, tcount;
  always #5 clk = ~clk;
  led_pwm_update_ctrl #(.TEST_DWELL(TD), .OVR_W(8)) dut (
    .clk(clk), .rst(rst), .store(store), .frame_data(frame_data), .period_end(period_end),
    .test_mode(test_mode), .data_red(data_red), .data_green(data_green), .data_blue(data_blue),
    .update(update), .pending(pending), .reject(reject), .overrun_cnt(overrun_cnt)
  );
  function automatic logic [31:0] frm(input logic [1:0] c, input logic [9:0] r, input logic [9:0] g, input logic [9:0] b);
    return {c, r, g, b};
  endfunction
  function automatic logic [29:0] colour(input int i);
    case (i)
      0: return {10'h3ff, 10'h000, 10'h000};
      1: return {10'h000, 10'h3ff, 10'h000};
      2: return {10'h000, 10'h000, 10'h3ff};
      3: return {10'h3ff, 10'h3ff, 10'h3ff};
      default: return 30'h0;
    endcase
  endfunction
  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    assert (act === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, act, exp);
    end
  endtask
  task automatic chk_all();
    chk("duty", {2'b0, data_red, data_green, data_blue}, {2'b0, m_du});
    chk("update", {31'b0, update}, {31'b0, m_upd});
    chk("pending", {31'b0, pending}, {31'b0, m_pend});
    chk("reject", {31'b0, reject}, {31'b0, m_rej});
    chk("overrun", {24'b0, overrun_cnt}, m_ovr);
  endtask
  task automatic model_reset();
    m_test = 0; m_pend = 0; m_upd = 0; m_rej = 0;
    m_sh = '0; m_sv = '0; m_du = '0; m_ovr = 0; tcount = 0;
  endtask
  task automatic model_step(input logic s, input logic [31:0] fd, input logic pe, input logic tm);
    bit v;
    logic [29:0] nf, c;
    v = s && (fd[31:30] == 2'b00 || fd[31:30] == 2'b11);
    nf = fd[31:30] == 2'b11 ? 30'h0 : fd[29:0];
    m_rej = s && (fd[31:30] == 2'b01 || fd[31:30] == 2'b10);
    m_upd = 0;
    if (!m_test) begin
      if (tm) begin
        m_test = 1;
        tcount = 0;
        if (m_pend && v) begin
          m_sh = nf;
          if (m_ovr < 255) m_ovr++;
        end
      end else begin
        if (m_pend && pe) begin
          m_du = m_sh; m_sv = m_sh; m_upd = 1; m_pend = 0;
        end
        if (v) begin
          if (m_pend && m_ovr < 255) m_ovr++;
          m_sh = nf; m_pend = 1;
        end
      end
    end else if (pe && !tm) begin
      m_du = m_pend ? m_sh : m_sv;
      m_sv = m_du;
      m_upd = 1; m_test = 0; m_pend = 0;
      if (v) begin m_sh = nf; m_pend = 1; end
    end else begin
      if (pe) begin
        c = colour((tcount / TD) % 5);
        m_upd = c != m_du;
        m_du = c;
        tcount++;
      end
      if (v) begin
        if (m_pend && m_ovr < 255) m_ovr++;
        m_sh = nf; m_pend = 1;
      end
    end
  endtask
  task automatic cyc(input logic s, input logic [31:0] fd, input logic pe, input logic tm);
    store = s; frame_data = fd; period_end = pe; test_mode = tm;
    @(posedge clk);
    model_step(s, fd, pe, tm);
    #1;
    chk_all();
  endtask
  initial begin
    bit s, pe, tm;
    logic [31:0] fd;
    rst = 1; store = 0; period_end = 0; test_mode = 0; frame_data = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk_all();
    rst = 0;
    cyc(1, frm(0, 10'h155, 10'h2AA, 10'h3FF), 0, 0);
    repeat (4) cyc(0, 0, 0, 0);
    cyc(0, 0, 1, 0);
    chk("plan1_red", {22'b0, data_red}, 32'h155);
    chk("plan1_blue", {22'b0, data_blue}, 32'h3FF);
    cyc(0, 0, 0, 0);
    cyc(1, frm(0, 10'h010, 0, 0), 0, 0);
    cyc(1, frm(0, 10'h020, 0, 0), 0, 0);
    cyc(0, 0, 1, 0);
    chk("plan2_ovr", {24'b0, overrun_cnt}, 32'd1);
    chk("plan2_red", {22'b0, data_red}, 32'h020);
    repeat (301) cyc(1, frm(0, 10'h033, 10'h1, 10'h2), 0, 0);
    chk("plan2_sat", {24'b0, overrun_cnt}, 32'hFF);
    cyc(0, 0, 1, 0);
    cyc(1, frm(0, 10'h100, 0, 0), 0, 0);
    cyc(1, frm(0, 10'h200, 0, 0), 1, 0);
    chk("plan3_red_old", {22'b0, data_red}, 32'h100);
    chk("plan3_pend", {31'b0, pending}, 32'd1);
    cyc(0, 0, 1, 0);
    chk("plan3_red_new", {22'b0, data_red}, 32'h200);
    cyc(1, frm(1, 10'h3, 10'h3, 10'h3), 0, 0);
    chk("plan4_reject", {31'b0, reject}, 32'd1);
    cyc(1, frm(3, 10'h3, 10'h3, 10'h3), 0, 0);
    cyc(0, 0, 1, 0);
    chk("plan4_blank", {2'b0, data_red, data_green, data_blue}, 32'h0);
    cyc(0, 0, 0, 1);
    for (int i = 0; i < 10; i++) begin
      cyc(0, 0, 1, 1);
      chk($sformatf("plan5_col%0d", i), {2'b0, data_red, data_green, data_blue}, {2'b0, colour((i / 2) % 5)});
      cyc(0, 0, 0, 1);
    end
    cyc(1, frm(0, 10'h0AA, 0, 0), 0, 1);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 1, 0);
    chk("plan5_exit_red", {22'b0, data_red}, 32'h0AA);
    cyc(1, frm(0, 10'h011, 0, 0), 0, 0);
    cyc(1, frm(0, 10'h022, 0, 0), 0, 0);
    rst = 1;
    #1;
    model_reset();
    chk_all();
    @(posedge clk);
    #1;
    rst = 0;
    cyc(0, 0, 1, 0);
    chk("plan6_no_update", {31'b0, update}, 32'd0);
    tm = 0;
    for (int i = 0; i < 3000; i++) begin
      s = $urandom_range(3) == 0;
      pe = $urandom_range(5) == 0;
      fd = $urandom;
      if ($urandom_range(2) != 0) fd[31:30] = $urandom_range(1) != 0 ? 2'b11 : 2'b00;
      if (!s && !pe && $urandom_range(39) == 0) tm = !tm;
      if (m_test && pe) s = 0;
      cyc(s, fd, pe, tm);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
